// File: rtl/evaluador_golpes.sv
// evaluador_golpes: judges drum-pad strikes against the note windows of 4
// lanes and produces registered score increments for the score accumulator.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   standBy        1 = paused; lanes forced idle, hits/windows ignored
//   notaActiva[4]  per-lane level: note inside the hit zone
//   golpe[4]       per-lane one-cycle strike pulse
//   puntos[13]     score increment, qualified by puntosValido (holds otherwise)
//   puntosValido   one-cycle strobe, at least one valid hit last cycle
//   combo[7]       consecutive-hit count, saturates at 127
//   multiplicador  1..4, derived from combo
//   fallo          one-cycle pulse on any miss or false hit

// Per-lane window tracker. Event outputs are combinational for the current
// cycle; the top registers the aggregated result.
module evaluador_golpes_carril #(
  parameter int CNT_W      = 8,
  parameter int PERFECT_LO = 8,
  parameter int PERFECT_HI = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic standBy,
  input  logic notaActiva,
  input  logic golpe,
  output logic hit,
  output logic perfecto,
  output logic falso,
  output logic miss
);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} estado_t;

  localparam logic [CNT_W-1:0] LO  = CNT_W'(PERFECT_LO);
  localparam logic [CNT_W-1:0] HI  = CNT_W'(PERFECT_HI);
  localparam logic [CNT_W-1:0] MAX = '1;

  estado_t          estado;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] edad;

  always_comb begin
    // In IDLE the current cycle is the first active one, so age is 0.
    edad     = (estado == ARMED) ? cnt : '0;
    hit      = !standBy && golpe && notaActiva && (estado != DONE);
    falso    = !standBy && golpe && (!notaActiva || (estado == DONE));
    miss     = !standBy && (estado == ARMED) && !notaActiva;
    perfecto = (edad >= LO) && (edad <= HI);
  end

  always_ff @(posedge clk) begin
    if (reset || standBy) begin
      estado <= IDLE;
      cnt    <= '0;
    end else begin
      case (estado)
        IDLE: if (notaActiva) begin
          estado <= hit ? DONE : ARMED;
          cnt    <= CNT_W'(1);  // next cycle is age 1
        end
        ARMED: begin
          if (!notaActiva) begin
            estado <= IDLE;
            cnt    <= '0;
          end else if (hit) begin
            estado <= DONE;
          end else if (cnt != MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: if (!notaActiva) begin
          estado <= IDLE;
          cnt    <= '0;
        end
        default: begin
          estado <= IDLE;
          cnt    <= '0;
        end
      endcase
    end
  end
endmodule

module evaluador_golpes #(
  parameter int CNT_W       = 8,
  parameter int PERFECT_LO  = 8,
  parameter int PERFECT_HI  = 24,
  parameter int PTS_PERFECT = 50,
  parameter int PTS_BUENO   = 20,
  parameter int COMBO_PASO  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        standBy,
  input  logic [3:0]  notaActiva,
  input  logic [3:0]  golpe,
  output logic [12:0] puntos,
  output logic        puntosValido,
  output logic [6:0]  combo,
  output logic [2:0]  multiplicador,
  output logic        fallo
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] hit, perfecto, falso, miss;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_carril
    evaluador_golpes_carril #(
      .CNT_W(CNT_W), .PERFECT_LO(PERFECT_LO), .PERFECT_HI(PERFECT_HI)
    ) u_carril (
      .clk(clk), .reset(reset), .standBy(standBy),
      .notaActiva(notaActiva[i]), .golpe(golpe[i]),
      .hit(hit[i]), .perfecto(perfecto[i]), .falso(falso[i]), .miss(miss[i])
    );
  end

  logic [7:0]  baseSum;
  logic [2:0]  nHits;
  logic        anyFail;
  logic [12:0] puntosCalc;
  logic [7:0]  comboSum;
  logic [6:0]  comboNext;
  logic [2:0]  multNext;
  int          paso;

  always_comb begin
    baseSum = '0;
    nHits   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (hit[i]) begin
        baseSum = baseSum + (perfecto[i] ? 8'(PTS_PERFECT) : 8'(PTS_BUENO));
        nHits   = nHits + 3'd1;
      end
    end
    anyFail = |(falso | miss);
    // Scoring uses the multiplier of the combo held before this cycle.
    puntosCalc = 13'(baseSum) * 13'(multiplicador);
    comboSum   = {1'b0, combo} + 8'(nHits);
    if (anyFail)             comboNext = '0;
    else if (comboSum > 127) comboNext = 7'd127;
    else                     comboNext = comboSum[6:0];
    paso     = int'(comboNext) / COMBO_PASO;
    multNext = (paso >= 3) ? 3'd4 : 3'(paso + 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      puntos        <= '0;
      puntosValido  <= 1'b0;
      combo         <= '0;
      multiplicador <= 3'd1;
      fallo         <= 1'b0;
    end else if (standBy) begin
      puntosValido <= 1'b0;
      fallo        <= 1'b0;
    end else begin
      puntosValido  <= |hit;
      if (|hit) puntos <= puntosCalc;
      fallo         <= anyFail;
      combo         <= comboNext;
      multiplicador <= multNext;
    end
  end
endmodule

// File: tb/tb_evaluador_golpes.sv
module tb_evaluador_golpes;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        standBy = 1'b0;
  logic [3:0]  notaActiva = '0;
  logic [3:0]  golpe = '0;
  logic [12:0] puntos;
  logic        puntosValido;
  logic [6:0]  combo;
  logic [2:0]  multiplicador;
  logic        fallo;

  int checks = 0;
  int errors = 0;

  evaluador_golpes dut (
    .clk(clk), .reset(reset), .standBy(standBy),
    .notaActiva(notaActiva), .golpe(golpe),
    .puntos(puntos), .puntosValido(puntosValido), .combo(combo),
    .multiplicador(multiplicador), .fallo(fallo)
  );

  always #5 clk = ~clk;

  // Reference model: each lane remembers the age of its open window
  // (-1 = no window) and whether that window was already scored.
  int  mAge[4];
  bit  mDone[4];
  int  mCombo, mMult, mPts;
  bit  mPV, mFallo, mValid = 0;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic modelStep(bit r, bit sb, logic [3:0] n, logic [3:0] g);
    int hits, base, a, s;
    bit fail;
    if (r) begin
      for (int i = 0; i < 4; i++) begin mAge[i] = -1; mDone[i] = 0; end
      mCombo = 0; mMult = 1; mPts = 0; mPV = 0; mFallo = 0; mValid = 1;
      return;
    end
    if (sb) begin
      for (int i = 0; i < 4; i++) begin mAge[i] = -1; mDone[i] = 0; end
      mPV = 0; mFallo = 0;
      return;
    end
    hits = 0; base = 0; fail = 0;
    for (int i = 0; i < 4; i++) begin
      if (n[i]) begin
        a = (mAge[i] < 0) ? 0 : mAge[i];
        if (g[i]) begin
          if (mDone[i]) fail = 1;
          else begin
            s = imin(a, 255);
            hits++;
            base += (s >= 8 && s <= 24) ? 50 : 20;
            mDone[i] = 1;
          end
        end
        mAge[i] = a + 1;
      end else begin
        if (g[i]) fail = 1;
        if (mAge[i] >= 0 && !mDone[i]) fail = 1;
        mAge[i] = -1; mDone[i] = 0;
      end
    end
    if (hits > 0) mPts = base * imin(1 + mCombo / 10, 4);
    mPV = (hits > 0);
    mFallo = fail;
    mCombo = fail ? 0 : imin(mCombo + hits, 127);
    mMult = imin(1 + mCombo / 10, 4);
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle after the first reset, all outputs must match the model.
  always @(negedge clk) begin
    if (mValid) begin
      chk("cmp_puntos", int'(puntos), mPts);
      chk("cmp_puntosValido", int'(puntosValido), int'(mPV));
      chk("cmp_combo", int'(combo), mCombo);
      chk("cmp_multiplicador", int'(multiplicador), mMult);
      chk("cmp_fallo", int'(fallo), int'(mFallo));
    end
  end

  task automatic tick(bit r, bit sb, logic [3:0] n, logic [3:0] g);
    reset = r; standBy = sb; notaActiva = n; golpe = g;
    @(posedge clk);
    modelStep(r, sb, n, g);
    @(negedge clk);
  endtask

  // Hold lane note for ages 0..age-1, then strike at 'age'.
  task automatic openHit(logic [3:0] lanes, int age, logic [3:0] extraG = '0);
    for (int a = 0; a < age; a++) tick(0, 0, lanes, '0);
    tick(0, 0, lanes, lanes | extraG);
  endtask

  task automatic hitsN(int k);
    for (int j = 0; j < k; j++) begin
      openHit(4'b0001, 10);
      tick(0, 0, '0, '0);
    end
  endtask

  task automatic doReset();
    tick(1, 0, '0, '0);
  endtask

  logic [3:0] rn, rg;
  bit rsb;

  initial begin
    // 1: reset with random inputs
    for (int k = 0; k < 2; k++) begin
      tick(1, 1'($urandom), 4'($urandom), 4'($urandom));
      chk("rst_puntos", int'(puntos), 0);
      chk("rst_pv", int'(puntosValido), 0);
      chk("rst_combo", int'(combo), 0);
      chk("rst_mult", int'(multiplicador), 1);
      chk("rst_fallo", int'(fallo), 0);
    end
    tick(0, 0, '0, '0);
    chk("rst_after_combo", int'(combo), 0);
    chk("rst_after_mult", int'(multiplicador), 1);

    // 2: PERFECT at age 10, repeat strike, GOOD at age 2
    openHit(4'b0001, 10);
    chk("t2_pts", int'(puntos), 50);
    chk("t2_pv", int'(puntosValido), 1);
    chk("t2_combo", int'(combo), 1);
    tick(0, 0, 4'b0001, '0);
    tick(0, 0, 4'b0001, 4'b0001);
    chk("t2_false_fallo", int'(fallo), 1);
    chk("t2_false_combo", int'(combo), 0);
    chk("t2_false_pv", int'(puntosValido), 0);
    tick(0, 0, '0, '0);
    chk("t2_done_close_fallo", int'(fallo), 0);
    openHit(4'b0001, 2);
    chk("t2_good_pts", int'(puntos), 20);
    tick(0, 0, '0, '0);

    // 3: multiplier step on lane 1
    doReset();
    for (int j = 0; j < 10; j++) begin
      openHit(4'b0010, 10);
      tick(0, 0, '0, '0);
    end
    chk("t3_combo10", int'(combo), 10);
    chk("t3_mult2", int'(multiplicador), 2);
    openHit(4'b0010, 10);
    chk("t3_pts100", int'(puntos), 100);
    chk("t3_combo11", int'(combo), 11);
    tick(0, 0, '0, '0);

    // 4: miss on lane 3
    for (int a = 0; a < 5; a++) tick(0, 0, 4'b1000, '0);
    tick(0, 0, '0, '0);
    chk("t4_fallo", int'(fallo), 1);
    chk("t4_combo", int'(combo), 0);
    chk("t4_pv", int'(puntosValido), 0);
    tick(0, 0, '0, '0);
    chk("t4_fallo_pulse", int'(fallo), 0);

    // 5: double hit at combo 9, then with a false hit on lane 1
    doReset();
    hitsN(9);
    openHit(4'b0101, 10);
    chk("t5_pts", int'(puntos), 100);
    chk("t5_combo", int'(combo), 11);
    chk("t5_mult", int'(multiplicador), 2);
    tick(0, 0, '0, '0);
    doReset();
    hitsN(9);
    openHit(4'b0101, 10, 4'b0010);
    chk("t5f_pts", int'(puntos), 100);
    chk("t5f_combo", int'(combo), 0);
    chk("t5f_fallo", int'(fallo), 1);
    tick(0, 0, '0, '0);

    // 6: standBy mid-window
    doReset();
    hitsN(5);
    for (int a = 0; a < 4; a++) tick(0, 0, 4'b0001, '0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 4'b0001, 4'($urandom) | 4'b0001);
      chk("t6_sb_pv", int'(puntosValido), 0);
      chk("t6_sb_fallo", int'(fallo), 0);
      chk("t6_sb_combo", int'(combo), 5);
    end
    openHit(4'b0001, 5);   // age restarts at 0, so age 5 is GOOD
    chk("t6_restart_pts", int'(puntos), 20);
    chk("t6_restart_combo", int'(combo), 6);
    tick(0, 0, '0, '0);

    // Random phase
    rn = '0; rsb = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 29) == 0) rn[i] = ~rn[i];
      for (int i = 0; i < 4; i++) rg[i] = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 79) == 0) rsb = ~rsb;
      tick(($urandom_range(0, 599) == 0), rsb, rn, rg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
